// File: rtl/move_request.sv
`default_nettype none
// ============================================================================
// Module   : move_request
// Brief    : Builds a source/target move request from two cursor selections,
//            holds it for the legality checker and commits legal moves.
// Revision : 1.0
// ============================================================================
module move_request #(
   parameter int unsigned  SETTLE_CYCLES = 2,
   parameter logic [255:0] INIT_BOARD    =
      256'h42365324_11111111_00000000_00000000_00000000_00000000_99999999_CABEDBAC
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         btnSelect,
   input  logic [5:0]   cursorSquare,
   input  logic         allowMove,
   output logic [13:0]  moveData,
   output logic         moveValid,
   output logic [255:0] boardOutput,
   output logic         turn,
   output logic         busy,
   output logic         rejected,
   output logic         committed
);

   localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_SRC_HELD = 2'd1,
      S_CHECK    = 2'd2,
      S_COMMIT   = 2'd3
   } state_t;

   state_t             r_state;
   logic [5:0]         r_src;
   logic [5:0]         r_tgt;
   logic [CNT_W-1:0]   r_cnt;
   logic [255:0]       r_board;
   logic               r_turn;
   logic               r_moveValid;
   logic               r_busy;
   logic               r_rejected;
   logic               r_committed;

   logic [3:0]         w_cursorNibble;
   logic               w_srcOk;

   // Source must hold a piece belonging to the side to move
   assign w_cursorNibble = r_board[{cursorSquare, 2'b00} +: 4];
   assign w_srcOk        = (w_cursorNibble != 4'h0) && (w_cursorNibble[3] == r_turn);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_src       <= 6'd0;
         r_tgt       <= 6'd0;
         r_cnt       <= '0;
         r_board     <= INIT_BOARD;
         r_turn      <= 1'b0;
         r_moveValid <= 1'b0;
         r_busy      <= 1'b0;
         r_rejected  <= 1'b0;
         r_committed <= 1'b0;
      end else begin
         r_rejected  <= 1'b0;
         r_committed <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (btnSelect) begin
                  if (w_srcOk) begin
                     r_src   <= cursorSquare;
                     r_state <= S_SRC_HELD;
                  end else begin
                     r_rejected <= 1'b1;
                  end
               end
            end
            S_SRC_HELD: begin
               if (btnSelect) begin
                  if (cursorSquare == r_src) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_tgt       <= cursorSquare;
                     r_cnt       <= CNT_W'(SETTLE_CYCLES);
                     r_moveValid <= 1'b1;
                     r_busy      <= 1'b1;
                     r_state     <= S_CHECK;
                  end
               end
            end
            S_CHECK: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else if (allowMove) begin
                  r_committed <= 1'b1;
                  r_moveValid <= 1'b0;
                  r_state     <= S_COMMIT;
               end else begin
                  r_rejected  <= 1'b1;
                  r_moveValid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            S_COMMIT: begin
               r_board[{r_tgt, 2'b00} +: 4] <= r_board[{r_src, 2'b00} +: 4];
               r_board[{r_src, 2'b00} +: 4] <= 4'h0;
               r_turn  <= ~r_turn;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign moveData    = {r_turn, 1'b0, r_src, r_tgt};
   assign moveValid   = r_moveValid;
   assign boardOutput = r_board;
   assign turn        = r_turn;
   assign busy        = r_busy;
   assign rejected    = r_rejected;
   assign committed   = r_committed;

endmodule
`default_nettype wire

// File: tb/tb_move_request.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_request
// Brief    : Directed vector bench for move_request (default and zero settle).
// Revision : 1.0
// ============================================================================
module tb_move_request;

   localparam logic [255:0] C_INIT =
      256'h42365324_11111111_00000000_00000000_00000000_00000000_99999999_CABEDBAC;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         btnSelect = 1'b0;
   logic [5:0]   cursorSquare = 6'd0;
   logic         allowMove = 1'b0;

   logic [13:0]  moveData, moveData0;
   logic         moveValid, moveValid0;
   logic [255:0] boardOutput, boardOutput0;
   logic         turn, turn0;
   logic         busy, busy0;
   logic         rejected, rejected0;
   logic         committed, committed0;

   move_request #(.SETTLE_CYCLES(2), .INIT_BOARD(C_INIT)) dut (
      .clk(clk), .reset(reset), .btnSelect(btnSelect), .cursorSquare(cursorSquare),
      .allowMove(allowMove), .moveData(moveData), .moveValid(moveValid),
      .boardOutput(boardOutput), .turn(turn), .busy(busy),
      .rejected(rejected), .committed(committed)
   );

   move_request #(.SETTLE_CYCLES(0), .INIT_BOARD(C_INIT)) dut0 (
      .clk(clk), .reset(reset), .btnSelect(btnSelect), .cursorSquare(cursorSquare),
      .allowMove(allowMove), .moveData(moveData0), .moveValid(moveValid0),
      .boardOutput(boardOutput0), .turn(turn0), .busy(busy0),
      .rejected(rejected0), .committed(committed0)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        rst;
      logic        btn;
      logic [5:0]  cur;
      logic        allow;
      logic [13:0] md;
      logic        mv, bz, rj, cm, tn;
      logic        moved;
   } vec_t;

   vec_t         vecs[16];
   logic [255:0] boardMoved;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic b, input logic [5:0] c, input logic a);
      @(negedge clk);
      reset        = r;
      btnSelect    = b;
      cursorSquare = c;
      allowMove    = a;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int rjCount;
      int cmCount;

      boardMoved = C_INIT;
      boardMoved[36*4 +: 4] = 4'h1;
      boardMoved[52*4 +: 4] = 4'h0;

      //          rst  btn  cur    allow md        mv bz rj cm tn moved
      vecs[0]  = '{1'b1, 1'b0, 6'd0,  1'b0, 14'h0000, 0, 0, 0, 0, 0, 0};
      vecs[1]  = '{1'b0, 1'b1, 6'd52, 1'b0, 14'h0D00, 0, 0, 0, 0, 0, 0};
      vecs[2]  = '{1'b0, 1'b1, 6'd36, 1'b0, 14'h0D24, 1, 1, 0, 0, 0, 0};
      vecs[3]  = '{1'b0, 1'b0, 6'd0,  1'b1, 14'h0D24, 1, 1, 0, 0, 0, 0};
      vecs[4]  = '{1'b0, 1'b0, 6'd0,  1'b1, 14'h0D24, 1, 1, 0, 0, 0, 0};
      vecs[5]  = '{1'b0, 1'b0, 6'd0,  1'b1, 14'h0D24, 0, 1, 0, 1, 0, 0};
      vecs[6]  = '{1'b0, 1'b0, 6'd0,  1'b0, 14'h2D24, 0, 0, 0, 0, 1, 1};
      vecs[7]  = '{1'b1, 1'b0, 6'd0,  1'b0, 14'h0000, 0, 0, 0, 0, 0, 0};
      vecs[8]  = '{1'b0, 1'b1, 6'd36, 1'b0, 14'h0000, 0, 0, 1, 0, 0, 0};
      vecs[9]  = '{1'b0, 1'b0, 6'd0,  1'b0, 14'h0000, 0, 0, 0, 0, 0, 0};
      vecs[10] = '{1'b0, 1'b1, 6'd12, 1'b0, 14'h0000, 0, 0, 1, 0, 0, 0};
      vecs[11] = '{1'b0, 1'b0, 6'd0,  1'b0, 14'h0000, 0, 0, 0, 0, 0, 0};
      vecs[12] = '{1'b0, 1'b1, 6'd52, 1'b0, 14'h0D00, 0, 0, 0, 0, 0, 0};
      vecs[13] = '{1'b0, 1'b1, 6'd52, 1'b0, 14'h0D00, 0, 0, 0, 0, 0, 0};
      vecs[14] = '{1'b0, 1'b1, 6'd51, 1'b0, 14'h0CC0, 0, 0, 0, 0, 0, 0};
      vecs[15] = '{1'b0, 1'b1, 6'd51, 1'b0, 14'h0CC0, 0, 0, 0, 0, 0, 0};

      for (int i = 0; i < 16; i++) begin
         step(vecs[i].rst, vecs[i].btn, vecs[i].cur, vecs[i].allow);
         chk($sformatf("vec%0d.md_mv_bz_rj_cm_tn", i),
             {moveData, moveValid, busy, rejected, committed, turn},
             {vecs[i].md, vecs[i].mv, vecs[i].bz, vecs[i].rj, vecs[i].cm, vecs[i].tn});
         chk($sformatf("vec%0d.board", i), boardOutput, vecs[i].moved ? boardMoved : C_INIT);
      end

      // Illegal move 52->20 with select pulses hammered during CHECK
      step(1'b0, 1'b1, 6'd52, 1'b0);
      step(1'b0, 1'b1, 6'd20, 1'b0);
      chk("illegal.moveData", moveData, 14'h0D14);
      rjCount = 0;
      cmCount = 0;
      for (int k = 1; k <= 5; k++) begin
         step(1'b0, (k <= 3) ? 1'b1 : 1'b0, 6'd36, 1'b0);
         if (rejected)  rjCount++;
         if (committed) cmCount++;
         if (k <= 2) chk($sformatf("illegal.hold%0d", k), {moveData, moveValid}, {14'h0D14, 1'b1});
      end
      chk("illegal.rejectedPulses", rjCount, 1);
      chk("illegal.committedPulses", cmCount, 0);
      chk("illegal.idle", {moveValid, busy, turn, moveData}, {3'b000, 14'h0D14});
      chk("illegal.board", boardOutput, C_INIT);

      // Legal white move, then reset while black's move is under evaluation
      step(1'b0, 1'b1, 6'd52, 1'b1);
      step(1'b0, 1'b1, 6'd36, 1'b1);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 6'd0, 1'b1);
      chk("abort.boardMoved", boardOutput, boardMoved);
      chk("abort.turnBlack", turn, 1'b1);
      step(1'b0, 1'b1, 6'd12, 1'b1);
      step(1'b0, 1'b1, 6'd28, 1'b1);
      chk("abort.blackCheck", {moveData, moveValid}, {14'h230C + 14'h0010, 1'b1});
      step(1'b1, 1'b0, 6'd0, 1'b1);
      chk("abort.resetState", {moveData, moveValid, busy, rejected, committed, turn}, 19'h0);
      chk("abort.board", boardOutput, C_INIT);
      rjCount = 0;
      cmCount = 0;
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b0, 6'd0, 1'b1);
         if (rejected)  rjCount++;
         if (committed) cmCount++;
      end
      chk("abort.noPulses", rjCount + cmCount, 0);

      // Zero settle: allowMove sampled in the first CHECK cycle
      step(1'b1, 1'b0, 6'd0, 1'b1);
      step(1'b0, 1'b1, 6'd52, 1'b1);
      step(1'b0, 1'b1, 6'd36, 1'b1);
      chk("settle0.check", {moveValid0, committed0, moveData0}, {2'b10, 14'h0D24});
      step(1'b0, 1'b0, 6'd0, 1'b1);
      chk("settle0.commit", {moveValid0, committed0, busy0}, 3'b011);
      step(1'b0, 1'b0, 6'd0, 1'b1);
      chk("settle0.board", boardOutput0, boardMoved);
      chk("settle0.turn", {turn0, committed0, rejected0, busy0}, 4'b1000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
